// File: rtl/billiard_pkg.sv
// Shared types and fixed-point constants for the white-ball motion block.
// Position is signed 32-bit, scaled by 64; speeds are signed 11-bit in 1/64 px/frame.
package billiard_pkg;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FIXED_POINT_SHIFT      = 6;

  typedef logic signed [10:0] speed_t;
  typedef logic signed [31:0] pos_t;

  typedef enum logic [1:0] {
    IDLE,
    ROLLING,
    POCKETED
  } ball_state_t;

endpackage

// File: rtl/ball_friction.sv
// Combinational friction for one axis: move |speed| toward zero by STEP,
// then snap to zero when the result is below MIN.
module ball_friction
  import billiard_pkg::*;
#(
  parameter int STEP = 2,
  parameter int MIN  = 8
) (
  input  speed_t i_speed,
  output speed_t o_speed
);

  localparam logic [11:0] L_STEP = 12'(STEP);
  localparam logic [11:0] L_MIN  = 12'(MIN);

  logic signed [11:0] w_ext;
  logic        [11:0] w_mag;
  logic        [11:0] w_dec;
  logic signed [11:0] w_out;

  // Magnitude is taken at 12 bits so that -1024 does not overflow.
  assign w_ext = 12'(i_speed);
  assign w_mag = w_ext[11] ? 12'(-w_ext) : w_ext;

  // NOTE: every combinational output gets a value on every path so no latch is inferred.
  always_comb begin
    w_dec = '0;
    if (w_mag > L_STEP) begin
      w_dec = w_mag - L_STEP;
    end
    if (w_dec < L_MIN) begin
      w_dec = '0;
    end
  end

  assign w_out   = w_ext[11] ? -$signed(w_dec) : $signed(w_dec);
  assign o_speed = w_out[10:0];

endmodule

// File: rtl/white_ball_motion.sv
// White-ball motion: shot loading, per-frame integration, friction, cushion
// reflection, pocketing and respawn. Optional position clamp: BALL_POS_CLAMP_EN.
module white_ball_motion
  import billiard_pkg::*;
#(
  parameter int INITIAL_X     = 160,
  parameter int INITIAL_Y     = 240,
  parameter int FRICTION_STEP = 2,
  parameter int MIN_SPEED     = 8,
  parameter int X_MIN         = 32,
  parameter int X_MAX         = 592,
  parameter int Y_MIN         = 32,
  parameter int Y_MAX         = 432
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                startOfFrame,
  input  logic                chargeWhiteBall,
  input  logic signed [10:0]  Xspeed_in,
  input  logic signed [10:0]  Yspeed_in,
  input  logic                collideLeft,
  input  logic                collideRight,
  input  logic                collideTop,
  input  logic                collideBottom,
  input  logic                pocketHit,
  input  logic                respawn,
  output logic signed [10:0]  WhiteBall_topLeftX,
  output logic signed [10:0]  WhiteBall_topLeftY,
  output logic signed [10:0]  WhiteBall_Xspeed,
  output logic signed [10:0]  WhiteBall_Yspeed,
  output logic                WhiteBall_inGame,
  output logic                ballMoving
);

  localparam pos_t INIT_POS_X = pos_t'(INITIAL_X * FIXED_POINT_MULTIPLIER);
  localparam pos_t INIT_POS_Y = pos_t'(INITIAL_Y * FIXED_POINT_MULTIPLIER);

  ball_state_t r_state, w_state_next;
  pos_t        r_pos_x, r_pos_y, w_pos_x_next, w_pos_y_next;
  speed_t      r_xspeed, r_yspeed, w_xspeed_next, w_yspeed_next;
  logic        r_in_game, w_in_game_next;
  logic        r_left, r_right, r_top, r_bottom, r_pocket;
  logic        w_left, w_right, w_top, w_bottom, w_pocket;
  logic        w_clear_flags;

  speed_t      w_xs_refl, w_ys_refl, w_xs_fric, w_ys_fric, w_xs_new, w_ys_new;
  pos_t        w_pos_x_int, w_pos_y_int, w_pos_x_new, w_pos_y_new;

  // A hit arriving in the same cycle as startOfFrame still counts for that frame.
  assign w_left   = r_left   | collideLeft;
  assign w_right  = r_right  | collideRight;
  assign w_top    = r_top    | collideTop;
  assign w_bottom = r_bottom | collideBottom;
  assign w_pocket = r_pocket | pocketHit;

  assign w_xs_refl = ((w_left && r_xspeed < 0) || (w_right && r_xspeed > 0)) ? -r_xspeed : r_xspeed;
  assign w_ys_refl = ((w_top && r_yspeed < 0) || (w_bottom && r_yspeed > 0)) ? -r_yspeed : r_yspeed;

  assign w_pos_x_int = r_pos_x + pos_t'(w_xs_refl);
  assign w_pos_y_int = r_pos_y + pos_t'(w_ys_refl);

  ball_friction #(.STEP(FRICTION_STEP), .MIN(MIN_SPEED)) u_fric_x (
    .i_speed (w_xs_refl),
    .o_speed (w_xs_fric)
  );

  ball_friction #(.STEP(FRICTION_STEP), .MIN(MIN_SPEED)) u_fric_y (
    .i_speed (w_ys_refl),
    .o_speed (w_ys_fric)
  );

`ifdef BALL_POS_CLAMP_EN
  pos_t w_tl_x, w_tl_y;
  assign w_tl_x = w_pos_x_int >>> FIXED_POINT_SHIFT;
  assign w_tl_y = w_pos_y_int >>> FIXED_POINT_SHIFT;

  always_comb begin
    w_pos_x_new = w_pos_x_int;
    w_xs_new    = w_xs_fric;
    if (w_tl_x < X_MIN) begin
      w_pos_x_new = pos_t'(X_MIN * FIXED_POINT_MULTIPLIER);
      w_xs_new    = '0;
    end else if (w_tl_x > X_MAX) begin
      w_pos_x_new = pos_t'(X_MAX * FIXED_POINT_MULTIPLIER);
      w_xs_new    = '0;
    end
    w_pos_y_new = w_pos_y_int;
    w_ys_new    = w_ys_fric;
    if (w_tl_y < Y_MIN) begin
      w_pos_y_new = pos_t'(Y_MIN * FIXED_POINT_MULTIPLIER);
      w_ys_new    = '0;
    end else if (w_tl_y > Y_MAX) begin
      w_pos_y_new = pos_t'(Y_MAX * FIXED_POINT_MULTIPLIER);
      w_ys_new    = '0;
    end
  end
`else
  assign w_pos_x_new = w_pos_x_int;
  assign w_pos_y_new = w_pos_y_int;
  assign w_xs_new    = w_xs_fric;
  assign w_ys_new    = w_ys_fric;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_pos_x_next   = r_pos_x;
    w_pos_y_next   = r_pos_y;
    w_xspeed_next  = r_xspeed;
    w_yspeed_next  = r_yspeed;
    w_in_game_next = r_in_game;
    w_clear_flags  = startOfFrame;
    unique case (r_state)
      IDLE: begin
        if (chargeWhiteBall && (Xspeed_in != 0 || Yspeed_in != 0)) begin
          w_xspeed_next = Xspeed_in;
          w_yspeed_next = Yspeed_in;
          w_state_next  = ROLLING;
        end
      end
      ROLLING: begin
        if (startOfFrame) begin
          if (w_pocket) begin
            w_xspeed_next  = '0;
            w_yspeed_next  = '0;
            w_in_game_next = 1'b0;
            w_state_next   = POCKETED;
          end else begin
            w_pos_x_next  = w_pos_x_new;
            w_pos_y_next  = w_pos_y_new;
            w_xspeed_next = w_xs_new;
            w_yspeed_next = w_ys_new;
            if (w_xs_new == 0 && w_ys_new == 0) begin
              w_state_next = IDLE;
            end
          end
        end
      end
      POCKETED: begin
        w_clear_flags = 1'b1;
        if (respawn) begin
          w_pos_x_next   = INIT_POS_X;
          w_pos_y_next   = INIT_POS_Y;
          w_in_game_next = 1'b1;
          w_state_next   = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pos_x   <= INIT_POS_X;
      r_pos_y   <= INIT_POS_Y;
      r_xspeed  <= '0;
      r_yspeed  <= '0;
      r_in_game <= 1'b1;
      r_left    <= 1'b0;
      r_right   <= 1'b0;
      r_top     <= 1'b0;
      r_bottom  <= 1'b0;
      r_pocket  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pos_x   <= w_pos_x_next;
      r_pos_y   <= w_pos_y_next;
      r_xspeed  <= w_xspeed_next;
      r_yspeed  <= w_yspeed_next;
      r_in_game <= w_in_game_next;
      r_left    <= w_clear_flags ? 1'b0 : w_left;
      r_right   <= w_clear_flags ? 1'b0 : w_right;
      r_top     <= w_clear_flags ? 1'b0 : w_top;
      r_bottom  <= w_clear_flags ? 1'b0 : w_bottom;
      r_pocket  <= w_clear_flags ? 1'b0 : w_pocket;
    end
  end

  // Top-left is (pos >>> 6) truncated to 11 bits, i.e. bits [16:6].
  assign WhiteBall_topLeftX = r_pos_x[16:6];
  assign WhiteBall_topLeftY = r_pos_y[16:6];
  assign WhiteBall_Xspeed   = r_xspeed;
  assign WhiteBall_Yspeed   = r_yspeed;
  assign WhiteBall_inGame   = r_in_game;
  assign ballMoving         = (r_state == ROLLING);

  logic w_unused_pos_bits;
  assign w_unused_pos_bits = ^{r_pos_x[31:17], r_pos_x[5:0], r_pos_y[31:17], r_pos_y[5:0]};

endmodule

// File: tb/tb_white_ball_motion.sv
// Directed bench for white_ball_motion (default build, clamp disabled).
// Expected values are hand-computed from the x64 fixed-point arithmetic.
module tb_white_ball_motion;

  logic               clk = 1'b0;
  logic               reset;
  logic               startOfFrame, chargeWhiteBall;
  logic signed [10:0] Xspeed_in, Yspeed_in;
  logic               collideLeft, collideRight, collideTop, collideBottom;
  logic               pocketHit, respawn;
  logic signed [10:0] WhiteBall_topLeftX, WhiteBall_topLeftY;
  logic signed [10:0] WhiteBall_Xspeed, WhiteBall_Yspeed;
  logic               WhiteBall_inGame, ballMoving;

  int n_chk = 0;
  int n_err = 0;

  white_ball_motion dut (
    .clk                (clk),
    .reset              (reset),
    .startOfFrame       (startOfFrame),
    .chargeWhiteBall    (chargeWhiteBall),
    .Xspeed_in          (Xspeed_in),
    .Yspeed_in          (Yspeed_in),
    .collideLeft        (collideLeft),
    .collideRight       (collideRight),
    .collideTop         (collideTop),
    .collideBottom      (collideBottom),
    .pocketHit          (pocketHit),
    .respawn            (respawn),
    .WhiteBall_topLeftX (WhiteBall_topLeftX),
    .WhiteBall_topLeftY (WhiteBall_topLeftY),
    .WhiteBall_Xspeed   (WhiteBall_Xspeed),
    .WhiteBall_Yspeed   (WhiteBall_Yspeed),
    .WhiteBall_inGame   (WhiteBall_inGame),
    .ballMoving         (ballMoving)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int x, input int y, input int xs, input int ys,
                         input int in_game, input int moving);
    chk({tag, ".x"},      WhiteBall_topLeftX, x);
    chk({tag, ".y"},      WhiteBall_topLeftY, y);
    chk({tag, ".xs"},     WhiteBall_Xspeed, xs);
    chk({tag, ".ys"},     WhiteBall_Yspeed, ys);
    chk({tag, ".ingame"}, {31'd0, WhiteBall_inGame}, in_game);
    chk({tag, ".moving"}, {31'd0, ballMoving}, moving);
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic charge(input int xs, input int ys);
    chargeWhiteBall = 1'b1;
    Xspeed_in       = 11'(xs);
    Yspeed_in       = 11'(ys);
    tick();
    chargeWhiteBall = 1'b0;
    Xspeed_in       = '0;
    Yspeed_in       = '0;
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; chargeWhiteBall = 1'b0;
    Xspeed_in = '0; Yspeed_in = '0;
    collideLeft = 1'b0; collideRight = 1'b0; collideTop = 1'b0; collideBottom = 1'b0;
    pocketHit = 1'b0; respawn = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_all("reset", 160, 240, 0, 0, 1, 0);

    // Shot X=256: loads on the charge edge, first frame moves 4 px.
    charge(256, 0);
    chk_all("charge256", 160, 240, 256, 0, 1, 1);
    sof();
    chk_all("frame1", 164, 240, 254, 0, 1, 1);

    // Pocket and cushion in the same frame: pocket wins, no integration.
    pocketHit = 1'b1; collideLeft = 1'b1;
    tick();
    pocketHit = 1'b0; collideLeft = 1'b0;
    tick();
    sof();
    chk_all("pocketed", 164, 240, 0, 0, 0, 0);
    charge(100, 0);
    chk("pocketed_charge_ignored", WhiteBall_Xspeed, 0);
    respawn = 1'b1;
    tick();
    respawn = 1'b0;
    chk_all("respawn", 160, 240, 0, 0, 1, 0);

    // Right cushion against +100: reflect, pos 10240-100 = 10140 -> 158 px.
    charge(100, 0);
    collideRight = 1'b1;
    tick();
    collideRight = 1'b0;
    sof();
    chk_all("right_reflect", 158, 240, -98, 0, 1, 1);
    sof();
    chk_all("after_reflect", 156, 240, -96, 0, 1, 1);
    collideRight = 1'b1;
    tick();
    collideRight = 1'b0;
    sof();
    chk_all("right_away", 155, 240, -94, 0, 1, 1);
    collideLeft = 1'b1;
    tick();
    collideLeft = 1'b0;
    sof();
    chk_all("left_reflect", 156, 240, 92, 0, 1, 1);
    sof();
    chk_all("left_cleared", 158, 240, 90, 0, 1, 1);

    // Second shot while rolling is ignored.
    charge(-300, 0);
    chk_all("rolling_charge", 158, 240, 90, 0, 1, 1);

    pocketHit = 1'b1;
    tick();
    pocketHit = 1'b0;
    sof();
    chk("pocket2.ingame", {31'd0, WhiteBall_inGame}, 0);
    respawn = 1'b1;
    tick();
    respawn = 1'b0;
    chk_all("respawn2", 160, 240, 0, 0, 1, 0);

    // Slow shot: 10 -> 8 -> 0 and back to IDLE.
    charge(10, 0);
    sof();
    chk_all("slow1", 160, 240, 8, 0, 1, 1);
    sof();
    chk_all("slow_stop", 160, 240, 0, 0, 1, 0);

    // All-zero shot ignored.
    charge(0, 0);
    chk_all("zero_shot", 160, 240, 0, 0, 1, 0);

    // Charge coincident with startOfFrame: speed loads, position unchanged.
    startOfFrame = 1'b1;
    charge(0, -64);
    startOfFrame = 1'b0;
    chk_all("charge_sof", 160, 240, 0, -64, 1, 1);
    sof();
    chk_all("up1", 160, 239, 0, -62, 1, 1);
    collideTop = 1'b1;
    sof();
    collideTop = 1'b0;
    chk_all("top_reflect", 160, 239, 0, 60, 1, 1);
    collideBottom = 1'b1;
    tick();
    collideBottom = 1'b0;
    sof();
    chk_all("bottom_reflect", 160, 239, 0, -58, 1, 1);

    // Reset mid-roll.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all("reset_midroll", 160, 240, 0, 0, 1, 0);

    // No clamp: 70 frames of 511,509,... travel 30940/64 px, past X_MAX=592.
    charge(511, 0);
    for (int i = 0; i < 70; i++) begin
      sof();
    end
    chk_all("no_clamp", 643, 240, 371, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
